tlc_demand_monitor: RTL and testbench

Upstream conditioning stage for the traffic-light controller. Synchronises and debounces the two raw vehicle-loop sensors, and converts debounced rising edges into single-cycle arrival pulses. Counts arrivals over a fixed time window and drives the controller's peak input with hysteresis. Outputs sensor1, sensor2 and peak connect directly to the controller's inputs of the same names.

---
 rtl/tlc_pkg.sv | 22 ++
 rtl/tlc_debounce.sv | 47 ++++
 rtl/tlc_demand_monitor.sv | 102 ++++++++++
 tb/tb_tlc_demand_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Definitions shared by the traffic-light controller and its demand monitor.
// Both sides take their light encoding and default timing from here so they agree.
package tlc_pkg;

    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] RED    = 2'd2;

    typedef logic [1:0] light_t;

    localparam int DEF_DEB_LEN  = 4;
    localparam int DEF_WINDOW   = 60;
    localparam int DEF_PEAK_ON  = 20;
    localparam int DEF_PEAK_OFF = 12;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic {
        OFFPEAK = 1'b0,
        PEAK    = 1'b1
    } peak_state_t;

endpackage

// File: rtl/tlc_debounce.sv
// Vehicle-loop conditioning: two-flop synchroniser, tick-sampled debouncer and
// a one-clk pulse on each debounced rising edge.
module tlc_debounce #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEB_LEN - 1);

    logic       sync_a;
    logic       sync_b;
    logic [3:0] mis_cnt;
    logic       flip;

    // flip marks the tick on which the DEB_LEN-th consecutive mismatch is seen
    assign flip = tick && (sync_b != level) && (mis_cnt == CNT_LAST);
    assign rise = flip && sync_b && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            mis_cnt <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (tick) begin
                if ((sync_b == level) || flip) begin
                    mis_cnt <= '0;
                end else begin
                    mis_cnt <= mis_cnt + 4'd1;
                end
                if (flip) begin
                    level <= sync_b;
                end
            end
        end
    end

endmodule

// File: rtl/tlc_demand_monitor.sv
// Demand monitor: debounced sensors, arrival pulses, per-window arrival count
// and the hysteretic peak-traffic flag fed to the controller.
//
// peak_state | meaning
// OFFPEAK    | normal traffic, peak=0
// PEAK       | heavy traffic, peak=1
module tlc_demand_monitor
    import tlc_pkg::*;
#(
    parameter int DEB_LEN  = DEF_DEB_LEN,
    parameter int WINDOW   = DEF_WINDOW,
    parameter int PEAK_ON  = DEF_PEAK_ON,
    parameter int PEAK_OFF = DEF_PEAK_OFF,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             sensor1_raw,
    input  logic             sensor2_raw,
    output logic             sensor1,
    output logic             sensor2,
    output logic             arrival1,
    output logic             arrival2,
    output logic             peak,
    output logic [CNT_W-1:0] window_count,
    output logic             window_done
);

    localparam int               SUM_W    = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       WIN_LAST = 8'(WINDOW - 1);

    logic [7:0]       win_left;
    logic [CNT_W-1:0] run_cnt;
    logic [SUM_W-1:0] run_sum;
    logic [CNT_W-1:0] run_sat;
    logic             boundary;
    peak_state_t      state_q;
    peak_state_t      state_d;

    tlc_debounce #(.DEB_LEN(DEB_LEN)) u_deb1 (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (sensor1_raw),
        .level (sensor1),
        .rise  (arrival1)
    );

    tlc_debounce #(.DEB_LEN(DEB_LEN)) u_deb2 (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (sensor2_raw),
        .level (sensor2),
        .rise  (arrival2)
    );

    // Window timer counts down; the terminal tick at zero is the boundary.
    assign boundary = tick && (win_left == 8'd0);

    // Running total including this cycle's arrivals, so boundary-cycle arrivals count.
    assign run_sum = {2'b00, run_cnt} + SUM_W'(arrival1) + SUM_W'(arrival2);
    assign run_sat = (run_sum > {2'b00, CNT_MAX}) ? CNT_MAX : run_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            win_left     <= WIN_LAST;
            run_cnt      <= '0;
            window_count <= '0;
            window_done  <= 1'b0;
            state_q      <= OFFPEAK;
        end else begin
            window_done <= boundary;
            state_q     <= state_d;
            if (tick) begin
                win_left <= (win_left == 8'd0) ? WIN_LAST : win_left - 8'd1;
            end
            if (boundary) begin
                window_count <= run_sat;
                run_cnt      <= '0;
            end else begin
                run_cnt <= run_sat;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (state_q)
                OFFPEAK: if (int'(run_sat) >= PEAK_ON)  state_d = PEAK;
                PEAK:    if (int'(run_sat) <= PEAK_OFF) state_d = OFFPEAK;
                default: state_d = OFFPEAK;
            endcase
        end
    end

    assign peak = (state_q == PEAK);

endmodule

// File: tb/tb_tlc_demand_monitor.sv
// Randomised bench for tlc_demand_monitor: a tick-level model predicts debounced
// levels, arrivals and per-window results; a monitor checks each window_done.
module tb_tlc_demand_monitor;

    localparam int DEB = 2;
    localparam int WIN = 40;
    localparam int ON  = 10;
    localparam int OFF = 6;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          sensor1_raw;
    logic          sensor2_raw;
    logic          sensor1;
    logic          sensor2;
    logic          arrival1;
    logic          arrival2;
    logic          peak;
    logic [CW-1:0] window_count;
    logic          window_done;

    tlc_demand_monitor #(
        .DEB_LEN (DEB),
        .WINDOW  (WIN),
        .PEAK_ON (ON),
        .PEAK_OFF(OFF),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .sensor1_raw (sensor1_raw),
        .sensor2_raw (sensor2_raw),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .arrival1    (arrival1),
        .arrival2    (arrival2),
        .peak        (peak),
        .window_count(window_count),
        .window_done (window_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          pk;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   stray_arrivals = 0;

    // Reference model state (tick granularity)
    int   run_len[2];
    logic s_prev[2];
    logic m_level[2];
    int   tick_idx;
    int   win_acc;
    logic m_peak;

    // Stimulus generator state
    logic gen_lvl[2];
    int   gen_hold[2];
    bit   busy[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            run_len[i] = 0;
            s_prev[i]  = 1'b0;
            m_level[i] = 1'b0;
        end
        tick_idx = 0;
        win_acc  = 0;
        m_peak   = 1'b0;
    endfunction

    // A sensor's debounced level follows its sampled level once that level has
    // differed from it for DEB consecutive ticks; arrivals are rises only.
    task automatic model_tick(input logic s1, input logic s2, output logic r1, output logic r2);
        logic s[2];
        logic r[2];
        int   val;
        s[0] = s1;
        s[1] = s2;
        for (int i = 0; i < 2; i++) begin
            run_len[i] = (tick_idx == 0 || s[i] != s_prev[i]) ? 1 : run_len[i] + 1;
            s_prev[i]  = s[i];
            r[i]       = 1'b0;
            if (s[i] != m_level[i] && run_len[i] >= DEB) begin
                r[i]       = s[i];
                m_level[i] = s[i];
            end
        end
        r1 = r[0];
        r2 = r[1];
        win_acc += int'(r[0]) + int'(r[1]);
        if (tick_idx % WIN == WIN - 1) begin
            val = (win_acc > SAT) ? SAT : win_acc;
            if (!m_peak && val >= ON)      m_peak = 1'b1;
            else if (m_peak && val <= OFF) m_peak = 1'b0;
            exp_q.push_back('{cnt: CW'(val), pk: m_peak});
            win_acc = 0;
        end
        tick_idx++;
    endtask

    function automatic void gen_step();
        for (int i = 0; i < 2; i++) begin
            if (gen_hold[i] == 0) begin
                gen_lvl[i]  = ~gen_lvl[i];
                gen_hold[i] = busy[i] ? DEB : $urandom_range(1, DEB + 5);
            end
            gen_hold[i]--;
        end
    endfunction

    // Entered and left on a negedge; raw levels settle through the
    // synchroniser before the tick that samples them.
    task automatic do_tick();
        logic r1, r2;
        gen_step();
        sensor1_raw = gen_lvl[0];
        sensor2_raw = gen_lvl[1];
        repeat ($urandom_range(2, 4)) @(negedge clk);
        tick = 1'b1;
        model_tick(gen_lvl[0], gen_lvl[1], r1, r2);
        #1;
        check("arrival1", 32'(arrival1), 32'(r1));
        check("arrival2", 32'(arrival2), 32'(r2));
        @(negedge clk);
        tick = 1'b0;
        check("sensor1", 32'(sensor1), 32'(m_level[0]));
        check("sensor2", 32'(sensor2), 32'(m_level[1]));
    endtask

    task automatic run_window();
        busy[0] = ($urandom_range(0, 2) == 0);
        busy[1] = ($urandom_range(0, 2) == 0);
        for (int t = 0; t < WIN; t++) do_tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!tick && (arrival1 || arrival2)) stray_arrivals++;
            if (window_done) begin
                if (exp_q.size() == 0) begin
                    check("window_done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("window_count", 32'(window_count), 32'(e.cnt));
                    check("peak", 32'(peak), 32'(e.pk));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        reset       = 1'b1;
        tick        = 1'b0;
        sensor1_raw = 1'b1;
        sensor2_raw = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sensor1", 32'(sensor1), 32'd0);
        check("rst_sensor2", 32'(sensor2), 32'd0);
        check("rst_arrival1", 32'(arrival1), 32'd0);
        check("rst_arrival2", 32'(arrival2), 32'd0);
        check("rst_peak", 32'(peak), 32'd0);
        check("rst_window_count", 32'(window_count), 32'd0);
        check("rst_window_done", 32'(window_done), 32'd0);
        reset = 1'b0;
        model_reset();

        // Sensor 1 held high from reset: it must rise on the DEB-th tick.
        gen_lvl[0]  = 1'b1;
        gen_hold[0] = DEB + 2;
        gen_lvl[1]  = 1'b0;
        gen_hold[1] = 1;

        for (int w = 0; w < 12; w++) run_window();

        // Busy window to raise peak, then reset part-way through the next one.
        busy[0] = 1'b1;
        busy[1] = 1'b1;
        for (int t = 0; t < WIN; t++) do_tick();
        for (int t = 0; t < 15; t++) do_tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_peak", 32'(peak), 32'd0);
        check("midrst_window_count", 32'(window_count), 32'd0);
        check("midrst_sensor1", 32'(sensor1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int w = 0; w < 8; w++) run_window();

        repeat (5) @(negedge clk);
        check("pending_windows", 32'(exp_q.size()), 32'd0);
        check("stray_arrivals", 32'(stray_arrivals), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
